// File: rtl/input_cond_pkg.sv
// -----------------------------------------------------------------------------
// input_cond_pkg
// Purpose : Shared constants for the board-input conditioner used by the
//           traffic light controller.
//           - Channel index constants: which async_in bit carries which
//             board signal.
//           - Default parameter values used by input_conditioner and
//             input_cond_channel.
// Ports   : none (package)
// Options : the sticky request latch is enabled by defining
//           INPUT_COND_LATCH_EN (see input_cond_channel).
// -----------------------------------------------------------------------------
package input_cond_pkg;

  // Board input assignment on async_in
  localparam int CH_RESET  = 0;
  localparam int CH_SENSOR = 1;
  localparam int CH_WALK   = 2;
  localparam int CH_REPROG = 3;

  // Default configuration
  localparam int DEF_NUM_CH          = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 3;

endpackage

// File: rtl/input_cond_channel.sv
// -----------------------------------------------------------------------------
// input_cond_channel
// Purpose : Conditions one asynchronous board input.
//           - SYNC_STAGES-flop synchronizer.
//           - Consecutive-cycle debounce filter (DEBOUNCE_CYCLES = 0 bypasses
//             the filter).
//           - Registered rise/fall pulses on the filtered level.
//           - Optional sticky request latch.
// Options : macro INPUT_COND_LATCH_EN enables the sticky latch. Without it,
//           req_latched is tied to 0 and latch_clr is ignored.
// Ports   :
//   clk          in   system clock, rising edge
//   Reset        in   synchronous active-high reset
//   async_in     in   raw asynchronous input
//   latch_clr    in   clear for req_latched (latch build only)
//   sync_level   out  synchronized, debounced level
//   rise_pulse   out  one-cycle pulse on a filtered 0->1 change
//   fall_pulse   out  one-cycle pulse on a filtered 1->0 change
//   req_latched  out  sticky rise-event flag
// -----------------------------------------------------------------------------
module input_cond_channel
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic Reset,
  input  logic async_in,
  input  logic latch_clr,
  output logic sync_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic req_latched
);

  // ---------------------------------------------------------------------------
  // Synchronizer chain; bit 0 samples the raw input, the MSB is the synced bit.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   synced;

  assign synced = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (Reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce filter: produces level_next, the value sync_level takes on the
  // coming edge.
  // ---------------------------------------------------------------------------
  logic level_reg;
  logic level_next;
  logic rise_reg;
  logic fall_reg;

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // The level register tracks the last synchronizer flop exactly: it loads
      // the same value on the same edge. This keeps the level latency at
      // SYNC_STAGES edges rather than adding one extra flop.
      logic unused_synced;
      assign unused_synced = synced;
      assign level_next    = sync_reg[SYNC_STAGES-2];
    end else begin : g_debounce
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             filt_next;

      // The counter holds the number of mismatching cycles already seen. The
      // level flips on the DEBOUNCE_CYCLES-th consecutive mismatch; any
      // agreement in between restarts the count.
      always_comb begin
        cnt_next  = '0;
        filt_next = level_reg;
        if (synced != level_reg) begin
          if (cnt_reg == CNT_LAST) begin
            filt_next = synced;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      assign level_next = filt_next;

      always_ff @(posedge clk) begin
        if (Reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Level and edge pulses. The pulses are computed from level_next, so each
  // one is high during the first cycle the new level is visible.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (Reset) begin
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      level_reg <= level_next;
      rise_reg  <= level_next & ~level_reg;
      fall_reg  <= ~level_next & level_reg;
    end
  end

  assign sync_level = level_reg;
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;

  // ---------------------------------------------------------------------------
  // Sticky request latch
  // ---------------------------------------------------------------------------
`ifdef INPUT_COND_LATCH_EN
  logic latch_reg;

  // Set takes priority over clear, so a rise arriving in the same cycle as a
  // clear is not lost.
  always_ff @(posedge clk) begin
    if (Reset) begin
      latch_reg <= 1'b0;
    end else begin
      latch_reg <= rise_reg | (latch_reg & ~latch_clr);
    end
  end

  assign req_latched = latch_reg;
`else
  logic unused_latch_clr;
  assign unused_latch_clr = latch_clr;
  assign req_latched      = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Purpose : Conditions NUM_CH asynchronous board inputs (reset button, car
//           sensor, walk request, reprogram) for the traffic light
//           controller. Each bit is handled by an independent
//           input_cond_channel.
// Options : macro INPUT_COND_LATCH_EN enables the per-channel sticky request
//           latch. Without it, req_latched is 0 and latch_clr is ignored.
// Ports   :
//   clk          in   system clock, rising edge
//   Reset        in   synchronous active-high reset
//   async_in     in   [NUM_CH] raw asynchronous inputs, bit i = channel i
//   latch_clr    in   [NUM_CH] per-channel req_latched clear
//   sync_level   out  [NUM_CH] synchronized, debounced levels
//   rise_pulse   out  [NUM_CH] one-cycle pulses on filtered 0->1 changes
//   fall_pulse   out  [NUM_CH] one-cycle pulses on filtered 1->0 changes
//   req_latched  out  [NUM_CH] sticky rise-event flags
// -----------------------------------------------------------------------------
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] async_in,
  input  logic [NUM_CH-1:0] latch_clr,
  output logic [NUM_CH-1:0] sync_level,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] req_latched
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      input_cond_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
        .clk         (clk),
        .Reset       (Reset),
        .async_in    (async_in[gi]),
        .latch_clr   (latch_clr[gi]),
        .sync_level  (sync_level[gi]),
        .rise_pulse  (rise_pulse[gi]),
        .fall_pulse  (fall_pulse[gi]),
        .req_latched (req_latched[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Self-checking bench for input_conditioner. Two instances share stimulus:
//   dut     default configuration (4 channels, 2 sync stages, debounce 3)
//   dut_bp  filter bypassed (3 sync stages, debounce 0)
// Expected values come from a history-based model: the level flips once the
// last DEBOUNCE_CYCLES synchronized samples all disagree with it; pulses are
// the level changes; the latch follows the set-wins rule.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int TB_S = 2;
  localparam int TB_D = 3;
  localparam int BP_S = 3;

  logic       clk;
  logic       Reset;
  logic [3:0] async_in;
  logic [3:0] latch_clr;
  logic [3:0] sync_level, rise_pulse, fall_pulse, req_latched;
  logic [3:0] bp_level, bp_rise, bp_fall, bp_latched;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state
  logic [3:0] hist[$];
  logic [3:0] lvl_m, rise_m, fall_m, latch_m;
  logic [3:0] bl_m, br_m, bf_m;

  input_conditioner #(
    .NUM_CH(4), .SYNC_STAGES(TB_S), .DEBOUNCE_CYCLES(TB_D)
  ) dut (
    .clk(clk), .Reset(Reset), .async_in(async_in), .latch_clr(latch_clr),
    .sync_level(sync_level), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .req_latched(req_latched)
  );

  input_conditioner #(
    .NUM_CH(4), .SYNC_STAGES(BP_S), .DEBOUNCE_CYCLES(0)
  ) dut_bp (
    .clk(clk), .Reset(Reset), .async_in(async_in), .latch_clr(latch_clr),
    .sync_level(bp_level), .rise_pulse(bp_rise),
    .fall_pulse(bp_fall), .req_latched(bp_latched)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Raw input sampled on edge k since the last reset (edge 1 = first one).
  function automatic logic in_at(input int k, input int ch);
    if (k >= 1 && k <= hist.size()) return hist[k-1][ch];
    return 1'b0;
  endfunction

  task automatic model_update(input logic [3:0] in_v, input logic [3:0] clr_v,
                              input logic rst_v);
    logic [3:0] new_l, new_b, latch_n;
    int n;
    logic flip;
    if (rst_v) begin
      hist.delete();
      lvl_m = '0; rise_m = '0; fall_m = '0; latch_m = '0;
      bl_m = '0;  br_m = '0;   bf_m = '0;
    end else begin
      hist.push_back(in_v);
      n = hist.size();
`ifdef INPUT_COND_LATCH_EN
      latch_n = rise_m | (latch_m & ~clr_v);
`else
      latch_n = 4'b0000;
`endif
      for (int ch = 0; ch < 4; ch++) begin
        // Synced value after edge m is the raw input of edge m-TB_S+1; the
        // decision on edge n looks at synced values after edges n-1..n-TB_D.
        flip = 1'b1;
        for (int j = 0; j < TB_D; j++)
          if (in_at(n - TB_S - j, ch) == lvl_m[ch]) flip = 1'b0;
        new_l[ch] = flip ? ~lvl_m[ch] : lvl_m[ch];
        new_b[ch] = in_at(n - BP_S + 1, ch);
      end
      rise_m  = new_l & ~lvl_m;
      fall_m  = ~new_l & lvl_m;
      lvl_m   = new_l;
      br_m    = new_b & ~bl_m;
      bf_m    = ~new_b & bl_m;
      bl_m    = new_b;
      latch_m = latch_n;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock transaction: drive, clock, update model, compare all outputs.
  task automatic step(input logic [3:0] in_v, input logic [3:0] clr_v,
                      input logic rst_v, input string tag);
    async_in  = in_v;
    latch_clr = clr_v;
    Reset     = rst_v;
    @(posedge clk);
    model_update(in_v, clr_v, rst_v);
    #1;
    chk({tag, "/level"},   sync_level,  lvl_m);
    chk({tag, "/rise"},    rise_pulse,  rise_m);
    chk({tag, "/fall"},    fall_pulse,  fall_m);
    chk({tag, "/latched"}, req_latched, latch_m);
    chk({tag, "/bp_level"}, bp_level,   bl_m);
    chk({tag, "/bp_rise"},  bp_rise,    br_m);
    chk({tag, "/bp_fall"},  bp_fall,    bf_m);
  endtask

  initial begin
    logic [3:0] exp_latch;
    logic [3:0] rin, rclr;
    logic       rrst;

    async_in = '0; latch_clr = '0; Reset = 1'b1;

    // Reset state
    for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 1'b1, "reset");
    chk("reset_level", sync_level, 4'b0000);
    chk("reset_pulses", rise_pulse | fall_pulse, 4'b0000);

    // One-cycle glitch on ch3: bypass instance passes it, filtered one rejects
    step(4'b1000, 4'b0000, 1'b0, "glitch");
    for (int k = 2; k <= 6; k++) begin
      step(4'b0000, 4'b0000, 1'b0, "glitch");
      if (k == 3) chk("bp_glitch_rise", bp_rise, 4'b1000);
      if (k == 4) chk("bp_glitch_fall", bp_fall, 4'b1000);
    end
    chk("glitch_filtered", sync_level, 4'b0000);

    // Sensor 0->1 held: level and single rise on edge 5
    for (int k = 1; k <= 8; k++) begin
      step(4'b0010, 4'b0000, 1'b0, "sensor_rise");
      if (k == 4) chk("sensor_e4_level", sync_level, 4'b0000);
      if (k == 5) chk("sensor_e5_rise", rise_pulse, 4'b0010);
      if (k == 5) chk("sensor_e5_level", sync_level, 4'b0010);
      if (k == 6) chk("sensor_e6_rise", rise_pulse, 4'b0000);
    end

    // Walk high for 2 cycles only: rejected
    step(4'b0110, 4'b0000, 1'b0, "walk_short");
    step(4'b0110, 4'b0000, 1'b0, "walk_short");
    for (int k = 0; k < 6; k++) step(4'b0010, 4'b0000, 1'b0, "walk_short");
    chk("walk_short_level", sync_level, 4'b0010);

    // All inputs high through reset: all rise together on edge 5 after release
    step(4'b1111, 4'b0000, 1'b1, "rst_held");
    step(4'b1111, 4'b0000, 1'b1, "rst_held");
    for (int k = 1; k <= 7; k++) begin
      step(4'b1111, 4'b0000, 1'b0, "rst_release");
      if (k == 5) chk("rst_release_rise", rise_pulse, 4'b1111);
    end

    // Ch0 falls: fall pulse on edge 5
    for (int k = 1; k <= 7; k++) begin
      step(4'b1110, 4'b0000, 1'b0, "ch0_fall");
      if (k == 5) chk("ch0_fall_pulse", fall_pulse, 4'b0001);
    end

    // Pending ch0 rise aborted by reset on edge 3
    step(4'b1111, 4'b0000, 1'b0, "abort");
    step(4'b1111, 4'b0000, 1'b0, "abort");
    step(4'b1111, 4'b0000, 1'b1, "abort_rst");
    for (int k = 0; k < 7; k++) step(4'b0000, 4'b0000, 1'b0, "abort_after");
    chk("abort_level", sync_level, 4'b0000);

    // Latch on walk channel
    for (int k = 1; k <= 7; k++) step(4'b0100, 4'b0000, 1'b0, "latch_set");
    for (int k = 1; k <= 7; k++) step(4'b0000, 4'b0000, 1'b0, "latch_hold");
`ifdef INPUT_COND_LATCH_EN
    exp_latch = 4'b0100;
`else
    exp_latch = 4'b0000;
`endif
    chk("latch_sticky", req_latched, exp_latch);
    // New rise: clear sampled on the edge right after the rise pulse
    for (int k = 1; k <= 5; k++) step(4'b0100, 4'b0000, 1'b0, "latch_rise2");
    step(4'b0100, 4'b0100, 1'b0, "latch_coincide");
    chk("latch_set_wins", req_latched, exp_latch);
    step(4'b0100, 4'b0000, 1'b0, "latch_hold2");
    step(4'b0100, 4'b0100, 1'b0, "latch_clr");
    chk("latch_cleared", req_latched, 4'b0000);

    // Randomized traffic with occasional resets and clears
    rin = 4'b0000;
    for (int k = 0; k < 500; k++) begin
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(0, 4) == 0) rin[ch] = ~rin[ch];
      rclr = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rrst = ($urandom_range(0, 99) == 0);
      step(rin, rclr, rrst, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
